// File: rtl/AXI_package.sv
// Shared register map for the Cicero AXI_top coprocessor and its host-side job loader.
// Holds command/status encodings, the loader state type and the result codes returned to the host.
package AXI_package;

    localparam int unsigned REG_WIDTH = 32;

    localparam logic [REG_WIDTH-1:0] CMD_NOP                = 32'd0;
    localparam logic [REG_WIDTH-1:0] CMD_WRITE              = 32'd1;
    localparam logic [REG_WIDTH-1:0] CMD_START              = 32'd2;
    localparam logic [REG_WIDTH-1:0] CMD_RESET              = 32'd3;
    localparam logic [REG_WIDTH-1:0] CMD_READ_ELAPSED_CLOCK = 32'd4;
    localparam logic [REG_WIDTH-1:0] CMD_RESTART            = 32'd5;

    localparam logic [REG_WIDTH-1:0] STATUS_IDLE     = 32'd0;
    localparam logic [REG_WIDTH-1:0] STATUS_RUNNING  = 32'd1;
    localparam logic [REG_WIDTH-1:0] STATUS_ACCEPTED = 32'd2;
    localparam logic [REG_WIDTH-1:0] STATUS_REJECTED = 32'd3;
    localparam logic [REG_WIDTH-1:0] STATUS_ERROR    = 32'd4;

    localparam logic [1:0] RESULT_ACCEPTED = 2'd0;
    localparam logic [1:0] RESULT_REJECTED = 2'd1;
    localparam logic [1:0] RESULT_ERROR    = 2'd2;
    localparam logic [1:0] RESULT_TIMEOUT  = 2'd3;

    typedef logic [3:0] loader_state_t;

    localparam loader_state_t ST_HDR     = 4'd0;
    localparam loader_state_t ST_DATA    = 4'd1;
    localparam loader_state_t ST_CCS     = 4'd2;
    localparam loader_state_t ST_CCE     = 4'd3;
    localparam loader_state_t ST_START   = 4'd4;
    localparam loader_state_t ST_RUN     = 4'd5;
    localparam loader_state_t ST_ELAPSED = 4'd6;
    localparam loader_state_t ST_RESULT  = 4'd7;
    localparam loader_state_t ST_RESTART = 4'd8;
    localparam loader_state_t ST_ABORT   = 4'd9;

    function automatic logic is_terminal(input logic [REG_WIDTH-1:0] status);
        return (status == STATUS_ACCEPTED) || (status == STATUS_REJECTED) ||
               (status == STATUS_ERROR);
    endfunction

    function automatic logic [1:0] result_code(input logic [REG_WIDTH-1:0] status);
        logic [1:0] code;
        code = RESULT_ERROR;
        if (status == STATUS_ACCEPTED) code = RESULT_ACCEPTED;
        else if (status == STATUS_REJECTED) code = RESULT_REJECTED;
        return code;
    endfunction

endpackage

// File: rtl/cicero_loader_watchdog.sv
// RUN-phase cycle counter for the job loader; flags expiry after TIMEOUT_CYCLES RUN cycles.
// Compiled only with CICERO_LOADER_TIMEOUT_EN.
`ifdef CICERO_LOADER_TIMEOUT_EN
module cicero_loader_watchdog
    import AXI_package::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    logic [REG_WIDTH-1:0] count_q;
    logic [REG_WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) count_d = '0;
        else if (enable_i) count_d = count_q + REG_WIDTH'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) count_q <= '0;
        else         count_q <= count_d;
    end

    assign expired_o = enable_i && (count_q == REG_WIDTH'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/cicero_job_loader.sv
// Host-side job sequencer driving AXI_top: loads an image, starts it, returns elapsed cycles.
// Optional RUN watchdog enabled by CICERO_LOADER_TIMEOUT_EN.
module cicero_job_loader
    import AXI_package::*;
#(
    parameter int unsigned BRAM_WRITE_ADDR_WIDTH = 10,
    parameter int unsigned TIMEOUT_CYCLES        = 1048576
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_WIDTH-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [REG_WIDTH-1:0] address_register,
    output logic [REG_WIDTH-1:0] data_in_register,
    output logic [REG_WIDTH-1:0] start_cc_pointer_register,
    output logic [REG_WIDTH-1:0] end_cc_pointer_register,
    output logic [REG_WIDTH-1:0] cmd_register,
    input  logic [REG_WIDTH-1:0] status_register,
    input  logic [REG_WIDTH-1:0] data_o_register,
    output logic [REG_WIDTH-1:0] result_data,
    output logic [1:0]           result_status,
    output logic                 result_valid,
    input  logic                 result_ready
);

    localparam int unsigned AW = BRAM_WRITE_ADDR_WIDTH;

    loader_state_t        state_q, state_d;
    logic [AW-1:0]        waddr_q, waddr_d;
    logic [9:0]           rem_q, rem_d;
    logic                 tmo_q, tmo_d;
    logic [REG_WIDTH-1:0] cmd_q, cmd_d;
    logic [REG_WIDTH-1:0] addr_q, addr_d;
    logic [REG_WIDTH-1:0] wdata_q, wdata_d;
    logic [REG_WIDTH-1:0] ccs_q, ccs_d;
    logic [REG_WIDTH-1:0] cce_q, cce_d;
    logic [REG_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]           rstat_q, rstat_d;
    logic                 rvalid_q, rvalid_d;
    logic                 hs;

    assign in_ready = (state_q == ST_HDR) || (state_q == ST_DATA) ||
                      (state_q == ST_CCS) || (state_q == ST_CCE);
    assign hs       = in_valid && in_ready;

`ifdef CICERO_LOADER_TIMEOUT_EN
    logic wd_expired;

    cicero_loader_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i    (clk),
        .rst_ni   (rst),
        .clear_i  ((state_q == ST_START) && (state_d == ST_RUN)),
        .enable_i (state_q == ST_RUN),
        .expired_o(wd_expired)
    );
`endif

    // cmd_d is the command for the cycle after this one, so it follows state_d
    always_comb begin
        state_d  = state_q;
        waddr_d  = waddr_q;
        rem_d    = rem_q;
        tmo_d    = tmo_q;
        cmd_d    = CMD_NOP;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        ccs_d    = ccs_q;
        cce_d    = cce_q;
        rdata_d  = rdata_q;
        rstat_d  = rstat_q;
        rvalid_d = rvalid_q;

        case (state_q)
            ST_HDR: begin
                if (hs) begin
                    waddr_d = in_data[AW-1:0];
                    rem_d   = in_data[25:16];
                    tmo_d   = 1'b0;
                    state_d = (in_data[25:16] != 10'd0) ? ST_DATA : ST_CCS;
                end
            end
            ST_DATA: begin
                if (hs) begin
                    cmd_d   = CMD_WRITE;
                    addr_d  = REG_WIDTH'(waddr_q);
                    wdata_d = in_data;
                    waddr_d = waddr_q + AW'(1);
                    rem_d   = rem_q - 10'd1;
                    if (rem_q == 10'd1) state_d = ST_CCS;
                end
            end
            ST_CCS: begin
                if (hs) begin
                    ccs_d   = in_data;
                    state_d = ST_CCE;
                end
            end
            ST_CCE: begin
                if (hs) begin
                    cce_d   = in_data;
                    state_d = ST_START;
                    cmd_d   = CMD_START;
                end
            end
            ST_START: begin
                if (status_register != STATUS_IDLE) state_d = ST_RUN;
                else                                cmd_d   = CMD_START;
            end
            ST_RUN: begin
                // a terminal status on the watchdog limit cycle takes priority
                if (is_terminal(status_register)) begin
                    rstat_d = result_code(status_register);
                    state_d = ST_ELAPSED;
                    cmd_d   = CMD_READ_ELAPSED_CLOCK;
                end
`ifdef CICERO_LOADER_TIMEOUT_EN
                else if (wd_expired) begin
                    state_d = ST_ABORT;
                    cmd_d   = CMD_RESET;
                end
`endif
            end
            ST_ELAPSED: begin
                rdata_d  = data_o_register;
                rvalid_d = 1'b1;
                state_d  = ST_RESULT;
            end
            ST_ABORT: begin
                rdata_d  = REG_WIDTH'(TIMEOUT_CYCLES);
                rstat_d  = RESULT_TIMEOUT;
                rvalid_d = 1'b1;
                tmo_d    = 1'b1;
                state_d  = ST_RESULT;
            end
            ST_RESULT: begin
                if (result_ready) begin
                    rvalid_d = 1'b0;
                    if (tmo_q) begin
                        state_d = ST_HDR;
                    end else begin
                        state_d = ST_RESTART;
                        cmd_d   = CMD_RESTART;
                    end
                end
            end
            ST_RESTART: begin
                if (status_register == STATUS_IDLE) state_d = ST_HDR;
                else                                cmd_d   = CMD_RESTART;
            end
            default: state_d = ST_HDR;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_HDR;
            waddr_q  <= '0;
            rem_q    <= '0;
            tmo_q    <= 1'b0;
            cmd_q    <= CMD_NOP;
            addr_q   <= '0;
            wdata_q  <= '0;
            ccs_q    <= '0;
            cce_q    <= '0;
            rdata_q  <= '0;
            rstat_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            waddr_q  <= waddr_d;
            rem_q    <= rem_d;
            tmo_q    <= tmo_d;
            cmd_q    <= cmd_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            ccs_q    <= ccs_d;
            cce_q    <= cce_d;
            rdata_q  <= rdata_d;
            rstat_q  <= rstat_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign cmd_register              = cmd_q;
    assign address_register          = addr_q;
    assign data_in_register          = wdata_q;
    assign start_cc_pointer_register = ccs_q;
    assign end_cc_pointer_register   = cce_q;
    assign result_data               = rdata_q;
    assign result_status             = rstat_q;
    assign result_valid              = rvalid_q;

endmodule

// File: tb/tb_cicero_job_loader.sv
// Randomised bench for cicero_job_loader: coprocessor model plus stream-level reference checker.
// Adds the watchdog job when CICERO_LOADER_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_cicero_job_loader;
    import AXI_package::*;

    localparam int unsigned TMO = 16;
`ifdef CICERO_LOADER_TIMEOUT_EN
    localparam int unsigned MAXLEN = 10;
`else
    localparam int unsigned MAXLEN = 50;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] address_register, data_in_register;
    logic [31:0] start_cc_pointer_register, end_cc_pointer_register;
    logic [31:0] cmd_register, status_register, data_o_register;
    logic [31:0] result_data;
    logic [1:0]  result_status;
    logic        result_valid;
    logic        result_ready;

    always #5 clk = ~clk;

    cicero_job_loader #(
        .BRAM_WRITE_ADDR_WIDTH(10),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .address_register(address_register), .data_in_register(data_in_register),
        .start_cc_pointer_register(start_cc_pointer_register),
        .end_cc_pointer_register(end_cc_pointer_register),
        .cmd_register(cmd_register), .status_register(status_register),
        .data_o_register(data_o_register),
        .result_data(result_data), .result_status(result_status),
        .result_valid(result_valid), .result_ready(result_ready)
    );

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- coprocessor model (AXI_top stand-in) ----------------
    localparam int unsigned CP_IDLE = 0, CP_RUN = 1, CP_DONE = 2;
    int unsigned cp_st = CP_IDLE;
    int unsigned cp_el = 0;
    logic [31:0] job_term = STATUS_ACCEPTED;
    int unsigned job_len  = 1;
    bit          job_hang = 1'b0;

    always @(posedge clk) begin
        if (cmd_register == CMD_RESET) begin
            cp_st <= CP_IDLE;
            cp_el <= 0;
        end else begin
            case (cp_st)
                CP_IDLE: if (cmd_register == CMD_START) begin cp_st <= CP_RUN; cp_el <= 0; end
                CP_RUN: begin
                    cp_el <= cp_el + 1;
                    if (!job_hang && cp_el + 1 == job_len) cp_st <= CP_DONE;
                end
                default: if (cmd_register == CMD_RESTART) cp_st <= CP_IDLE;
            endcase
        end
    end

    always_comb begin
        status_register = job_term;
        if (cp_st == CP_IDLE) status_register = STATUS_IDLE;
        else if (cp_st == CP_RUN) status_register = STATUS_RUNNING;
    end
    always_comb data_o_register = (cmd_register == CMD_READ_ELAPSED_CLOCK) ? cp_el : 32'hDEADBEEF;

    // ---------------- stream-level reference and compare process ----------------
    // phases: 0 header, 1 data, 2 ccs, 3 cce, 4 job busy, 5 result taken / waiting for loader
    int unsigned ncyc = 0;
    int unsigned m_ph = 0;
    int unsigned m_base, m_n, m_i;
    logic [31:0] m_ccs = '0, m_cce = '0;
    bit          wr_pend = 1'b0;
    logic [9:0]  wr_addr;
    logic [31:0] wr_data;
    bit          hs_flag = 1'b0;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_rstat;
    int unsigned cnt_reset = 0, cnt_restart = 0;
    int unsigned wlog_cyc[$];
    logic [9:0]  wlog_addr[$];

    always @(negedge clk) begin
        ncyc++;
        hs_flag = 1'b0;
        if (!rst) begin
            m_ph    = 0;
            wr_pend = 1'b0;
        end else begin
            if (wr_pend) begin
                chk("wr_cmd", cmd_register, CMD_WRITE);
                chk("wr_addr", address_register, {22'd0, wr_addr});
                chk("wr_data", data_in_register, wr_data);
                wlog_cyc.push_back(ncyc);
                wlog_addr.push_back(address_register[9:0]);
            end else if (m_ph <= 3) begin
                chk("load_cmd_nop", cmd_register, CMD_NOP);
            end else begin
                chk("no_stray_write", {31'd0, cmd_register != CMD_WRITE}, 32'd1);
            end
            wr_pend = 1'b0;
            if (cmd_register == CMD_RESET)   cnt_reset++;
            if (cmd_register == CMD_RESTART) cnt_restart++;

            if (m_ph == 5 && in_ready) m_ph = 0;
            if (m_ph <= 3) begin
                chk("in_ready_load", {31'd0, in_ready}, 32'd1);
                chk("rvalid_load", {31'd0, result_valid}, 32'd0);
            end else if (m_ph == 4) begin
                chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
                chk("start_cc", start_cc_pointer_register, m_ccs);
                chk("end_cc", end_cc_pointer_register, m_cce);
                if (result_valid) begin
                    chk("result_data", result_data, exp_rdata);
                    chk("result_status", {30'd0, result_status}, {30'd0, exp_rstat});
                    if (result_ready) m_ph = 5;
                end
            end else begin
                chk("rvalid_after", {31'd0, result_valid}, 32'd0);
            end

            if (in_valid && in_ready) begin
                hs_flag = 1'b1;
                case (m_ph)
                    0: begin
                        m_base = int'(in_data[9:0]);
                        m_n    = int'(in_data[25:16]);
                        m_i    = 0;
                        m_ph   = (m_n != 0) ? 1 : 2;
                    end
                    1: begin
                        wr_pend = 1'b1;
                        wr_addr = 10'((m_base + m_i) % 1024);
                        wr_data = in_data;
                        m_i++;
                        if (m_i == m_n) m_ph = 2;
                    end
                    2: begin m_ccs = in_data; m_ph = 3; end
                    3: begin m_cce = in_data; m_ph = 4; end
                    default: ;
                endcase
            end
        end
    end

    // ---------------- driver ----------------
    function automatic logic [1:0] exp_code(input logic [31:0] t);
        if (t == STATUS_ACCEPTED) return 2'd0;
        if (t == STATUS_REJECTED) return 2'd1;
        return 2'd2;
    endfunction

    function automatic logic [31:0] rand_term();
        int unsigned k;
        k = $urandom_range(0, 2);
        if (k == 0) return STATUS_ACCEPTED;
        if (k == 1) return STATUS_REJECTED;
        return STATUS_ERROR;
    endfunction

    // mode: 0 back-to-back, 1 alternate valid, 2 random gaps
    task automatic run_job(input logic [9:0] base, input int unsigned n, input int unsigned mode,
                           input logic [31:0] term, input int unsigned len, input bit hang,
                           input int unsigned hold, input int unsigned abort_after,
                           input logic [31:0] ccs, input logic [31:0] cce);
        logic [31:0] words[$];
        int unsigned idx, guard;
        bit v;
        words.push_back({6'd0, 10'(n), 6'd0, base});
        for (int k = 0; k < int'(n); k++) words.push_back($urandom);
        words.push_back(ccs);
        words.push_back(cce);
        job_term = term;
        job_len  = len;
        job_hang = hang;
        if (hang) begin exp_rstat = 2'd3; exp_rdata = TMO; end
        else      begin exp_rstat = exp_code(term); exp_rdata = len; end
        cnt_reset = 0;
        cnt_restart = 0;
        wlog_cyc.delete();
        wlog_addr.delete();

        idx = 0;
        guard = 0;
        while (idx < words.size() && guard < 5000) begin
            @(posedge clk); #1;
            if (hs_flag) idx++;
            if (abort_after != 0 && idx == abort_after + 1) break;
            if (idx >= words.size()) break;
            if (mode == 0)      v = 1'b1;
            else if (mode == 1) v = (guard % 2 == 0);
            else                v = ($urandom_range(0, 3) != 0);
            in_valid = v;
            in_data  = v ? words[idx] : $urandom;
            guard++;
        end
        in_valid = 1'b0;
        if (guard >= 5000) chk("stream_wait_timeout", 32'd1, 32'd0);

        if (abort_after != 0) begin
            chk("abort_pre_write", cmd_register, CMD_WRITE);
            #2 rst = 1'b0;
            #1;
            chk("abort_cmd", cmd_register, CMD_NOP);
            chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
            chk("abort_addr", address_register, 32'd0);
            chk("abort_data", data_in_register, 32'd0);
            @(posedge clk); #1 rst = 1'b1;
            return;
        end

        guard = 0;
        while (!result_valid && guard < 5000) begin @(negedge clk); guard++; end
        if (guard >= 5000) begin
            chk("result_wait_timeout", 32'd1, 32'd0);
            return;
        end
        for (int h = 0; h < int'(hold); h++) begin
            @(posedge clk); #1;
            chk("hold_valid", {31'd0, result_valid}, 32'd1);
        end
        @(posedge clk); #1 result_ready = 1'b1;
        @(posedge clk); #1 result_ready = 1'b0;

        guard = 0;
        while (!in_ready && guard < 5000) begin @(negedge clk); guard++; end
        if (guard >= 5000) chk("reload_wait_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        chk("reset_cmd_cycles", cnt_reset, hang ? 32'd1 : 32'd0);
        if (hang) chk("restart_cycles", cnt_restart, 32'd0);
        else      chk("restart_seen", {31'd0, cnt_restart >= 1}, 32'd1);
    endtask

    initial begin
        logic [9:0] a0, a1, a2;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; result_ready = 1'b0;
        #1 rst = 1'b0;
        #2;
        chk("rst_cmd", cmd_register, CMD_NOP);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_addr", address_register, 32'd0);
        chk("rst_data_in", data_in_register, 32'd0);
        chk("rst_ccs", start_cc_pointer_register, 32'd0);
        chk("rst_cce", end_cc_pointer_register, 32'd0);
        chk("rst_rdata", result_data, 32'd0);
        chk("rst_rstat", {30'd0, result_status}, 32'd0);
        chk("rst_rvalid", {31'd0, result_valid}, 32'd0);
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // wrap across the top of BRAM on consecutive cycles
        run_job(10'h3FE, 3, 0, STATUS_ACCEPTED, 5, 1'b0, 0, 0, $urandom, $urandom);
        a0 = 10'h3FE; a1 = 10'h3FF; a2 = 10'h000;
        chk("wrap_count", wlog_addr.size(), 32'd3);
        if (wlog_addr.size() == 3) begin
            chk("wrap_a0", {22'd0, wlog_addr[0]}, {22'd0, a0});
            chk("wrap_a1", {22'd0, wlog_addr[1]}, {22'd0, a1});
            chk("wrap_a2", {22'd0, wlog_addr[2]}, {22'd0, a2});
            chk("wrap_consec1", wlog_cyc[1], wlog_cyc[0] + 1);
            chk("wrap_consec2", wlog_cyc[2], wlog_cyc[1] + 1);
        end

        // empty image, accepted after a long run
        run_job(10'h000, 0, 2, STATUS_ACCEPTED, (MAXLEN < 40) ? MAXLEN : 40, 1'b0, 2, 0,
                32'd5, 32'd9);
        chk("lit_ccs", start_cc_pointer_register, 32'd5);
        chk("lit_cce", end_cc_pointer_register, 32'd9);
        chk("lit_rdata", result_data, (MAXLEN < 40) ? MAXLEN : 32'd40);
        chk("lit_rstat", {30'd0, result_status}, 32'd0);

        // error result held while the host stalls
        run_job(10'($urandom), 4, 2, STATUS_ERROR, 7, 1'b0, 10, 0, $urandom, $urandom);
        chk("lit_err_status", {30'd0, result_status}, 32'd2);
        chk("lit_err_data", result_data, 32'd7);

        // reset after the first of four data words, then a clean job
        run_job(10'h010, 4, 0, STATUS_ACCEPTED, 3, 1'b0, 0, 1, $urandom, $urandom);
        run_job(10'h020, 4, 0, STATUS_REJECTED, 4, 1'b0, 1, 0, $urandom, $urandom);
        chk("lit_rej_status", {30'd0, result_status}, 32'd1);

        // valid toggling during DATA
        run_job(10'h3FC, 6, 1, STATUS_ACCEPTED, 6, 1'b0, 0, 0, $urandom, $urandom);
        chk("toggle_writes", wlog_addr.size(), 32'd6);

        for (int j = 0; j < 8; j++) begin
            run_job(10'($urandom), $urandom_range(0, 20), $urandom_range(0, 2), rand_term(),
                    $urandom_range(1, MAXLEN), 1'b0, $urandom_range(0, 5), 0,
                    $urandom, $urandom);
        end

`ifdef CICERO_LOADER_TIMEOUT_EN
        run_job(10'h100, 2, 0, STATUS_ACCEPTED, 1, 1'b1, 3, 0, $urandom, $urandom);
        chk("lit_tmo_status", {30'd0, result_status}, 32'd3);
        chk("lit_tmo_data", result_data, 32'd16);
        run_job(10'h200, 1, 0, STATUS_ACCEPTED, 4, 1'b0, 0, 0, $urandom, $urandom);
`endif

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
